// File: rtl/robotron_dbg_pkg.sv
// Shared definitions for the robotron bus-trace debug unit.
// Holds capture-state encoding, trigger-mode codes and record layout helpers.
package robotron_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_POST  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] BP_ANY = 2'b00;
    localparam logic [1:0] BP_RD  = 2'b01;
    localparam logic [1:0] BP_WR  = 2'b10;
    localparam logic [1:0] BP_OFF = 2'b11;

    // Record layout, LSB first: data, then address, then rw on top.
    localparam int REC_DATA_LSB = 0;

    function automatic int rec_addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int rec_rw_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int rec_width(input int aw, input int dw);
        return aw + dw + 1;
    endfunction

endpackage

// File: rtl/bus_trace_match.sv
// One address-window trigger channel: combinational window and rw compare.
// Ports: addr/rw (bus cycle), lo/hi (inclusive window), mode (BP_*), hit.
module bus_trace_match
    import robotron_dbg_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    input  logic [1:0]        mode,
    output logic              hit
);

    logic in_win;
    logic rw_ok;

    // A window with lo > hi can never satisfy both bounds.
    assign in_win = (addr >= lo) && (addr <= hi);

    always_comb begin
        rw_ok = 1'b0;
        unique case (mode)
            BP_ANY: rw_ok = 1'b1;
            BP_RD:  rw_ok = rw;
            BP_WR:  rw_ok = ~rw;
            BP_OFF: rw_ok = 1'b0;
        endcase
    end

    assign hit = in_win && rw_ok;

endmodule

// File: rtl/robotron_bus_trace.sv
// 6809 bus-cycle trace: circular capture with address-window trigger,
// post-trigger count and a pop interface for draining the buffer.
// Ports: clk/reset; cyc_en/bus_* sample inputs; arm; bp_lo/bp_hi/bp_mode
// trigger channels; post_count; rd_req/rd_data/rd_valid/rd_empty readout;
// state, trig_chan, fill status.
module robotron_bus_trace
    import robotron_dbg_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int NUM_BP = 2,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cyc_en,
    input  logic                     bus_vma,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [DATA_W-1:0]        bus_data,
    input  logic                     bus_rw,
    input  logic                     arm,
    input  logic [NUM_BP*ADDR_W-1:0] bp_lo,
    input  logic [NUM_BP*ADDR_W-1:0] bp_hi,
    input  logic [NUM_BP*2-1:0]      bp_mode,
    input  logic [PW-1:0]            post_count,
    input  logic                     rd_req,
    output logic [ADDR_W+DATA_W:0]   rd_data,
    output logic                     rd_valid,
    output logic                     rd_empty,
    output logic [1:0]               state,
    output logic [NUM_BP-1:0]        trig_chan,
    output logic [PW:0]              fill
);

    localparam int REC_W   = rec_width(ADDR_W, DATA_W);
    localparam int ADDR_LO = rec_addr_lsb(DATA_W);
    localparam int RW_BIT  = rec_rw_bit(ADDR_W, DATA_W);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    state_t            state_q;
    state_t            state_nxt;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     post_cnt;
    logic [NUM_BP-1:0] hit;
    logic [REC_W-1:0]  rec;
    logic [REC_W-1:0]  mem [DEPTH];
    logic [PW:0]       fill_inc;
    logic              sample;
    logic              store;
    logic              trig;
    logic              enter_done;
    logic              pop;

    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        bus_trace_match #(.ADDR_W(ADDR_W)) u_match (
            .addr (bus_addr),
            .rw   (bus_rw),
            .lo   (bp_lo[i*ADDR_W +: ADDR_W]),
            .hi   (bp_hi[i*ADDR_W +: ADDR_W]),
            .mode (bp_mode[i*2 +: 2]),
            .hit  (hit[i])
        );
    end

    always_comb begin
        rec = '0;
        rec[REC_DATA_LSB +: DATA_W] = bus_data;
        rec[ADDR_LO +: ADDR_W]      = bus_addr;
        rec[RW_BIT]                 = bus_rw;
    end

    assign sample   = cyc_en && bus_vma;
    assign store    = !arm && sample &&
                      (state_q == ST_ARMED || state_q == ST_POST);
    assign trig     = store && state_q == ST_ARMED && |hit;
    assign pop      = !arm && state_q == ST_DONE && rd_req && fill != '0;
    assign fill_inc = (fill == FULL) ? fill : fill + 1'b1;

    // post_count is PW bits, so it never exceeds DEPTH-1 and the
    // trigger sample always survives in the buffer.
    always_comb begin
        state_nxt = state_q;
        if (arm) begin
            state_nxt = ST_ARMED;
        end else begin
            unique case (state_q)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_ARMED: if (trig)
                    state_nxt = (post_count == '0) ? ST_DONE : ST_POST;
                ST_POST:  if (store && post_cnt == PW'(1))
                    state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_DONE;
            endcase
        end
    end

    assign enter_done = state_q != ST_DONE && state_nxt == ST_DONE;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            fill      <= '0;
            trig_chan <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (arm) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                post_cnt  <= '0;
                fill      <= '0;
                trig_chan <= '0;
            end else begin
                if (store) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    fill   <= fill_inc;
                end
                if (trig) begin
                    trig_chan <= hit;
                    post_cnt  <= post_count;
                end else if (store && state_q == ST_POST) begin
                    post_cnt <= post_cnt - 1'b1;
                end
                // Oldest entry sits at the next write slot once wrapped.
                if (enter_done)
                    rd_ptr <= (fill_inc == FULL) ? wr_ptr + 1'b1 : '0;
                if (pop) begin
                    rd_valid <= 1'b1;
                    rd_data  <= mem[rd_ptr];
                    rd_ptr   <= rd_ptr + 1'b1;
                    fill     <= fill - 1'b1;
                end
            end
        end
    end

    assign state    = state_q;
    assign rd_empty = (state_q == ST_DONE) ? (fill == '0) : 1'b1;

endmodule

// File: tb/tb_robotron_bus_trace.sv
// Self-checking bench for robotron_bus_trace: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_robotron_bus_trace;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int NB = 2;
    localparam int PW = 4;
    localparam int RW = AW + DW + 1;

    logic            clk = 0;
    logic            reset = 1;
    logic            cyc_en = 0;
    logic            bus_vma = 0;
    logic [AW-1:0]   bus_addr = 0;
    logic [DW-1:0]   bus_data = 0;
    logic            bus_rw = 0;
    logic            arm = 0;
    logic [AW-1:0]   lo_a [NB];
    logic [AW-1:0]   hi_a [NB];
    logic [1:0]      md_a [NB];
    logic [NB*AW-1:0] bp_lo, bp_hi;
    logic [NB*2-1:0] bp_mode;
    logic [PW-1:0]   post_count = 0;
    logic            rd_req = 0;
    logic [RW-1:0]   rd_data;
    logic            rd_valid, rd_empty;
    logic [1:0]      state;
    logic [NB-1:0]   trig_chan;
    logic [PW:0]     fill;

    assign bp_lo   = {lo_a[1], lo_a[0]};
    assign bp_hi   = {hi_a[1], hi_a[0]};
    assign bp_mode = {md_a[1], md_a[0]};

    robotron_bus_trace dut (
        .clk(clk), .reset(reset), .cyc_en(cyc_en), .bus_vma(bus_vma),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw(bus_rw),
        .arm(arm), .bp_lo(bp_lo), .bp_hi(bp_hi), .bp_mode(bp_mode),
        .post_count(post_count), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_empty(rd_empty), .state(state),
        .trig_chan(trig_chan), .fill(fill)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: captured samples kept as a queue, oldest first.
    int            m_state = 0;
    logic [RW-1:0] q [$];
    logic [NB-1:0] m_trig = 0;
    int            m_post = 0;
    logic          m_rdv = 0;
    logic [RW-1:0] m_rdd = 0;

    function automatic logic [NB-1:0] match_mask();
        logic [NB-1:0] m = 0;
        for (int i = 0; i < NB; i++) begin
            if (md_a[i] != 2'd3 && bus_addr >= lo_a[i] &&
                bus_addr <= hi_a[i] &&
                (md_a[i] == 2'd0 || (md_a[i] == 2'd1 && bus_rw) ||
                 (md_a[i] == 2'd2 && !bus_rw)))
                m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic m_push();
        q.push_back({bus_rw, bus_addr, bus_data});
        if (q.size() > DEPTH) void'(q.pop_front());
    endtask

    always @(posedge clk) begin : model
        logic [NB-1:0] mk;
        logic s;
        if (reset) begin
            m_state = 0; q.delete(); m_trig = 0;
            m_rdv = 0; m_rdd = 0; m_post = 0;
        end else begin
            m_rdv = 0;
            s = cyc_en && bus_vma;
            mk = match_mask();
            if (arm) begin
                m_state = 1; q.delete(); m_trig = 0;
            end else if (m_state == 1) begin
                if (s) begin
                    m_push();
                    if (mk != 0) begin
                        m_trig = mk;
                        m_post = post_count;
                        m_state = (m_post == 0) ? 3 : 2;
                    end
                end
            end else if (m_state == 2) begin
                if (s) begin
                    m_push();
                    m_post--;
                    if (m_post == 0) m_state = 3;
                end
            end else if (m_state == 3) begin
                if (rd_req && q.size() > 0) begin
                    m_rdd = q.pop_front();
                    m_rdv = 1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("state", state, m_state);
        chk("fill", fill, q.size());
        chk("rd_empty", rd_empty, (m_state != 3) || (q.size() == 0));
        chk("trig_chan", trig_chan, m_trig);
        chk("rd_valid", rd_valid, m_rdv);
        if (m_rdv) chk("rd_data", rd_data, m_rdd);
    end

    task automatic tick();
        @(posedge clk); #1;
        arm = 0; rd_req = 0; cyc_en = 0; bus_vma = 0;
    endtask

    task automatic smp(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rw);
        cyc_en = 1; bus_vma = 1; bus_addr = a; bus_data = d; bus_rw = rw;
        tick();
    endtask

    task automatic do_arm();
        arm = 1;
        tick();
    endtask

    task automatic pop(output logic v, output logic [AW-1:0] a);
        rd_req = 1;
        tick();
        v = rd_valid;
        a = rd_data[AW+DW-1:DW];
    endtask

    task automatic set_bp(input int ch, input logic [AW-1:0] l,
                          input logic [AW-1:0] h, input logic [1:0] m);
        lo_a[ch] = l; hi_a[ch] = h; md_a[ch] = m;
    endtask

    logic          v;
    logic [AW-1:0] a;

    initial begin
        set_bp(0, 16'h0, 16'h0, 2'd3);
        set_bp(1, 16'h0, 16'h0, 2'd3);
        tick(); tick();
        reset = 0;
        tick();
        chk("rst_state", state, 0);
        chk("rst_fill", fill, 0);
        chk("rst_empty", rd_empty, 1);
        chk("rst_rdata", rd_data, 0);

        // Idle: samples without arm are not captured.
        set_bp(0, 16'hC000, 16'hC0FF, 2'd0);
        for (int i = 0; i < 20; i++) smp(16'hC000 + 16'(i), 8'(i), 1);
        chk("idle_state", state, 0);
        chk("idle_fill", fill, 0);

        // Basic trigger with three post samples.
        post_count = 3;
        do_arm();
        for (int i = 0; i < 10; i++) smp(16'h0100 + 16'(i), 8'(i), 1);
        cyc_en = 1; bus_vma = 0; bus_addr = 16'hC010; tick();
        chk("novma_state", state, 1);
        smp(16'hC010, 8'hAA, 1);
        for (int i = 0; i < 4; i++) smp(16'h0200 + 16'(i), 8'h50, 0);
        chk("t2_state", state, 3);
        chk("t2_fill", fill, 14);
        chk("t2_trig", trig_chan, 2'b01);
        for (int i = 1; i <= 14; i++) begin
            pop(v, a);
            if (i == 1)  chk("t2_pop1", a, 16'h0100);
            if (i == 11) chk("t2_pop11", a, 16'hC010);
            if (i == 14) chk("t2_pop14", a, 16'h0202);
        end
        chk("t2_empty", rd_empty, 1);
        pop(v, a);
        chk("t2_pop_empty", v, 0);

        // Wrap-around: oldest survivor is sample 27.
        post_count = 2;
        do_arm();
        for (int n = 0; n < 40; n++) smp(16'(n), 8'(n), 1);
        smp(16'hC000, 8'h77, 0);
        smp(16'd100, 8'h1, 1);
        smp(16'd101, 8'h2, 1);
        chk("wrap_fill", fill, 16);
        pop(v, a);
        chk("wrap_first", a, 16'd27);
        rd_req = 1;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
        end
        rd_req = 0;
        chk("burst_fill", fill, 0);
        chk("burst_noval", rd_valid, 0);

        // Mode filtering.
        set_bp(0, 16'hCA00, 16'hCA07, 2'd2);
        set_bp(1, 16'hCA00, 16'hCA07, 2'd1);
        post_count = 0;
        do_arm();
        smp(16'hCA01, 8'h11, 0);
        chk("wr_trig", trig_chan, 2'b01);
        chk("wr_state", state, 3);
        do_arm();
        smp(16'hCA01, 8'h22, 1);
        chk("rd_trig", trig_chan, 2'b10);
        md_a[0] = 2'd3; md_a[1] = 2'd3;
        do_arm();
        smp(16'hCA01, 8'h1, 0);
        smp(16'hCA01, 8'h2, 1);
        smp(16'hCA00, 8'h3, 1);
        chk("off_state", state, 1);
        chk("off_fill", fill, 3);

        // Inverted window never matches.
        set_bp(0, 16'h5000, 16'h4000, 2'd0);
        do_arm();
        smp(16'h4800, 8'h0, 1);
        smp(16'h5000, 8'h0, 1);
        smp(16'h4000, 8'h0, 0);
        chk("inv_state", state, 1);

        // Overlapping channels, post_count 0.
        set_bp(0, 16'h8000, 16'h9FFF, 2'd0);
        set_bp(1, 16'h9000, 16'h9000, 2'd0);
        do_arm();
        for (int i = 0; i < 3; i++) smp(16'h1000 + 16'(i), 8'(i), 1);
        smp(16'h9000, 8'h90, 1);
        chk("ovl_state", state, 3);
        chk("ovl_trig", trig_chan, 2'b11);
        chk("ovl_fill", fill, 4);
        for (int i = 1; i <= 4; i++) begin
            pop(v, a);
            if (i == 4) chk("ovl_newest", a, 16'h9000);
        end

        // Maximum post count: trigger survives as oldest entry.
        post_count = 4'd15;
        do_arm();
        smp(16'h1000, 8'h0, 1);
        smp(16'h1001, 8'h0, 1);
        smp(16'h9000, 8'h90, 0);
        for (int i = 0; i < 14; i++) smp(16'h2000 + 16'(i), 8'(i), 1);
        chk("max_post14", state, 2);
        smp(16'h200E, 8'h0, 1);
        chk("max_post15", state, 3);
        for (int i = 0; i < 5; i++) smp(16'h3000 + 16'(i), 8'(i), 1);
        chk("max_fill", fill, 16);
        pop(v, a);
        chk("max_oldest", a, 16'h9000);

        // Arm coincident with a matching sample.
        set_bp(0, 16'hC000, 16'hC0FF, 2'd0);
        md_a[1] = 2'd3;
        post_count = 5;
        arm = 1; cyc_en = 1; bus_vma = 1; bus_addr = 16'hC010; bus_rw = 1;
        tick();
        chk("armcol_state", state, 1);
        chk("armcol_fill", fill, 0);

        // Reset during POST.
        smp(16'hC010, 8'h5, 1);
        smp(16'h0300, 8'h6, 1);
        chk("pre_rst_post", state, 2);
        reset = 1; tick(); reset = 0;
        chk("rstpost_state", state, 0);
        chk("rstpost_fill", fill, 0);
        chk("rstpost_valid", rd_valid, 0);

        // Reset coincident with a read request.
        post_count = 0;
        do_arm();
        smp(16'h0400, 8'h1, 1);
        smp(16'hC020, 8'h2, 1);
        rd_req = 1; reset = 1; tick(); reset = 0;
        chk("rstrd_valid", rd_valid, 0);
        chk("rstrd_state", state, 0);

        // Arm coincident with a read request drops the read.
        do_arm();
        smp(16'hC030, 8'h3, 1);
        chk("armrd_pre", fill, 1);
        arm = 1; rd_req = 1; tick();
        chk("armrd_valid", rd_valid, 0);
        chk("armrd_state", state, 1);
        chk("armrd_fill", fill, 0);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
